// File: rtl/sd_access_arbiter_pkg.sv
// Shared types and constants for the SD-card sector controller arbiter.
package sd_arb_pkg;

  localparam int unsigned SD_ARB_N_REQ = 6;
  localparam int unsigned SD_ARB_LBA_W = 32;

  localparam int unsigned REQ_C1541 = 0;
  localparam int unsigned REQ_CRT   = 1;
  localparam int unsigned REQ_PRG   = 2;
  localparam int unsigned REQ_ROM   = 3;
  localparam int unsigned REQ_TAP   = 4;
  localparam int unsigned REQ_FLT   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } sd_arb_state_t;

endpackage

// File: rtl/sd_access_arbiter_if.sv
// Requester-side and controller-side signals of the SD access arbiter.
interface sd_access_arbiter_if
  import sd_arb_pkg::*;
#(
  parameter int unsigned N_REQ = SD_ARB_N_REQ,
  parameter int unsigned LBA_W = SD_ARB_LBA_W
);

  logic [N_REQ*LBA_W-1:0] req_lba;
  logic [N_REQ-1:0]       req_rd;
  logic [N_REQ-1:0]       req_wr;
  logic [N_REQ*8-1:0]     req_wr_data;
  logic [N_REQ-1:0]       req_busy;
  logic [N_REQ-1:0]       req_done;
  logic [N_REQ-1:0]       req_err;
  logic [N_REQ-1:0]       req_rd_strobe;
  logic [N_REQ-1:0]       grant;
  logic [LBA_W-1:0]       sd_lba;
  logic                   sd_rd;
  logic                   sd_wr;
  logic [7:0]             sd_wr_data;
  logic                   sd_busy;
  logic                   sd_done;
  logic                   sd_rd_byte_strobe;

  // Arbiter view.
  modport slave (
    input  req_lba, req_rd, req_wr, req_wr_data, sd_busy, sd_done, sd_rd_byte_strobe,
    output req_busy, req_done, req_err, req_rd_strobe, grant, sd_lba, sd_rd, sd_wr,
           sd_wr_data
  );

  // Requesters plus controller view.
  modport master (
    output req_lba, req_rd, req_wr, req_wr_data, sd_busy, sd_done, sd_rd_byte_strobe,
    input  req_busy, req_done, req_err, req_rd_strobe, grant, sd_lba, sd_rd, sd_wr,
           sd_wr_data
  );

endinterface

// File: rtl/sd_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first request found searching from last_i + 1.
module sd_rr_pick #(
  parameter int unsigned N_REQ = 6,
  parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            found;
  logic [IdxW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = IdxW'((32'(last_i) + k) % N_REQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/sd_access_arbiter.sv
// Shares one SD sector controller between the c1541 drive and the image loaders.
module sd_access_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned N_REQ         = SD_ARB_N_REQ,
  parameter int unsigned LBA_W         = SD_ARB_LBA_W,
  parameter int unsigned ISSUE_TIMEOUT = 1_000_000
) (
  input logic                clk,
  input logic                reset_n,
  sd_access_arbiter_if.slave bus
);

  localparam int unsigned     IdxW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned     CntW     = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(ISSUE_TIMEOUT);
  localparam logic [IdxW-1:0] LastInit = IdxW'(N_REQ - 1);

  sd_arb_state_t    state_q, state_d;
  logic [N_REQ-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic [LBA_W-1:0] lba_q [N_REQ];
  logic [LBA_W-1:0] sd_lba_q, sd_lba_d, pick_lba;
  logic             sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [IdxW-1:0]  last_q, last_d, pick_idx;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] pend, accept, conflict, pick_gnt;
  logic [7:0]       wr_data;

  assign pend     = pend_rd_q | pend_wr_q;
  // Requesters already pending or owning the controller cannot queue a second operation.
  assign accept   = (bus.req_rd | bus.req_wr) & ~(pend | grant_q);
  assign conflict = bus.req_rd & bus.req_wr;

  sd_rr_pick #(
    .N_REQ(N_REQ),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (pend),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    pick_lba = '0;
    wr_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_lba = pick_lba | lba_q[i];
      if (grant_q[i])  wr_data  = wr_data | bus.req_wr_data[i*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q | (accept & bus.req_rd);
    pend_wr_d = pend_wr_q | (accept & bus.req_wr & ~bus.req_rd);
    grant_d   = grant_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    err_d     = conflict;
    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          grant_d  = pick_gnt;
          sd_lba_d = pick_lba;
          last_d   = pick_idx;
          cnt_d    = '0;
          if (|(pick_gnt & pend_rd_q)) begin
            sd_rd_d   = 1'b1;
            pend_rd_d = pend_rd_d & ~pick_gnt;
          end else begin
            sd_wr_d   = 1'b1;
            pend_wr_d = pend_wr_d & ~pick_gnt;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        if (bus.sd_busy) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_d == CntMax) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          err_d   = err_d | grant_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.sd_done) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      sd_lba_q  <= '0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      last_q    <= LastInit;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) lba_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sd_lba_q  <= sd_lba_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (accept[i]) lba_q[i] <= bus.req_lba[i*LBA_W +: LBA_W];
      end
    end
  end

  assign bus.req_busy      = pend | grant_q;
  assign bus.req_done      = done_q;
  assign bus.req_err       = err_q;
  assign bus.req_rd_strobe = {N_REQ{bus.sd_rd_byte_strobe}} & grant_q;
  assign bus.grant         = grant_q;
  assign bus.sd_lba        = sd_lba_q;
  assign bus.sd_rd         = sd_rd_q;
  assign bus.sd_wr         = sd_wr_q;
  assign bus.sd_wr_data    = wr_data;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter: transaction table plus multi-cycle sequences.
module tb_sd_access_arbiter;
  import sd_arb_pkg::*;

  localparam int unsigned NReq = 6;
  localparam int unsigned LbaW = 32;
  localparam int unsigned Tmo  = 100;

  typedef struct {
    int unsigned idx;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [7:0]  wdata;
    int unsigned wait_cycles;
    int unsigned nstrobe;
    logic [5:0]  exp_grant;
    logic        exp_rd;
    logic        exp_wr;
    logic [5:0]  exp_err;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  sd_access_arbiter_if #(.N_REQ(NReq), .LBA_W(LbaW)) bus ();

  sd_access_arbiter #(
    .N_REQ        (NReq),
    .LBA_W        (LbaW),
    .ISSUE_TIMEOUT(Tmo)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned idx, input logic rd, input logic wr,
                         input logic [31:0] lba, input logic [7:0] wd);
    bus.req_rd[idx]                = rd;
    bus.req_wr[idx]                = wr;
    bus.req_lba[idx*LbaW +: LbaW]  = lba;
    bus.req_wr_data[idx*8 +: 8]    = wd;
  endtask

  task automatic clr_req();
    bus.req_rd = '0;
    bus.req_wr = '0;
  endtask

  // Called at a sample point where the owner's command is asserted.
  task automatic serve(input logic [5:0] owner, input string tag);
    bus.sd_busy = 1'b1;
    step();
    chk({tag, "_cmd_drop"}, 64'(bus.sd_rd | bus.sd_wr), 64'(0));
    bus.sd_busy = 1'b0;
    bus.sd_done = 1'b1;
    step();
    bus.sd_done = 1'b0;
    chk({tag, "_done"}, 64'(bus.req_done), 64'(owner));
    chk({tag, "_grant_clr"}, 64'(bus.grant), 64'(0));
  endtask

  task automatic run_txn(input vec_t v, input int id);
    string       t;
    int unsigned n, s_own, s_oth;
    t = $sformatf("vec%0d", id);
    step();
    set_req(v.idx, v.rd, v.wr, v.lba, v.wdata);
    step();
    clr_req();
    chk({t, "_busy"}, 64'(bus.req_busy), 64'(v.exp_grant));
    chk({t, "_err"}, 64'(bus.req_err), 64'(v.exp_err));
    chk({t, "_grant_early"}, 64'(bus.grant), 64'(0));
    step();
    chk({t, "_grant"}, 64'(bus.grant), 64'(v.exp_grant));
    chk({t, "_lba"}, 64'(bus.sd_lba), 64'(v.lba));
    chk({t, "_sd_rd"}, 64'(bus.sd_rd), 64'(v.exp_rd));
    chk({t, "_sd_wr"}, 64'(bus.sd_wr), 64'(v.exp_wr));
    chk({t, "_wdata"}, 64'(bus.sd_wr_data), 64'(v.wdata));
    chk({t, "_err_clr"}, 64'(bus.req_err), 64'(0));
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.sd_rd || bus.sd_wr) n++;
      if (k == 3) bus.sd_busy = 1'b1;
      step();
    end
    chk({t, "_cmd_cycles"}, 64'(n), 64'(4));
    s_own = 0;
    s_oth = 0;
    for (int unsigned w = 0; w < v.wait_cycles; w++) begin
      if (w < v.nstrobe) bus.sd_rd_byte_strobe = 1'b1;
      if (v.exp_wr && w < 3) bus.req_wr_data[v.idx*8 +: 8] = 8'(8'h5A + w);
      #1;
      if (|(bus.req_rd_strobe & v.exp_grant))  s_own++;
      if (|(bus.req_rd_strobe & ~v.exp_grant)) s_oth++;
      if (v.exp_wr && w < 3) chk({t, "_wdata_track"}, 64'(bus.sd_wr_data), 64'(8'(8'h5A + w)));
      step();
      bus.sd_rd_byte_strobe = 1'b0;
    end
    chk({t, "_strobe_owner"}, 64'(s_own), 64'(v.nstrobe));
    chk({t, "_strobe_other"}, 64'(s_oth), 64'(0));
    chk({t, "_grant_hold"}, 64'(bus.grant), 64'(v.exp_grant));
    bus.sd_busy = 1'b0;
    bus.sd_done = 1'b1;
    step();
    bus.sd_done = 1'b0;
    chk({t, "_done"}, 64'(bus.req_done), 64'(v.exp_grant));
    chk({t, "_grant_clr"}, 64'(bus.grant), 64'(0));
    chk({t, "_busy_clr"}, 64'(bus.req_busy), 64'(0));
    step();
    chk({t, "_done_once"}, 64'(bus.req_done), 64'(0));
  endtask

  initial begin
    int unsigned n;

    vecs[0] = '{idx: REQ_PRG, rd: 1'b1, wr: 1'b0, lba: 32'h10, wdata: 8'h00, wait_cycles: 600,
                nstrobe: 0, exp_grant: 6'b000100, exp_rd: 1'b1, exp_wr: 1'b0, exp_err: 6'b0};
    vecs[1] = '{idx: REQ_CRT, rd: 1'b1, wr: 1'b0, lba: 32'h111, wdata: 8'h11, wait_cycles: 600,
                nstrobe: 512, exp_grant: 6'b000010, exp_rd: 1'b1, exp_wr: 1'b0, exp_err: 6'b0};
    vecs[2] = '{idx: REQ_TAP, rd: 1'b0, wr: 1'b1, lba: 32'h4444, wdata: 8'hA5, wait_cycles: 20,
                nstrobe: 0, exp_grant: 6'b010000, exp_rd: 1'b0, exp_wr: 1'b1, exp_err: 6'b0};
    vecs[3] = '{idx: REQ_CRT, rd: 1'b1, wr: 1'b1, lba: 32'h10, wdata: 8'h3C, wait_cycles: 5,
                nstrobe: 0, exp_grant: 6'b000010, exp_rd: 1'b1, exp_wr: 1'b0,
                exp_err: 6'b000010};
    vecs[4] = '{idx: REQ_C1541, rd: 1'b0, wr: 1'b1, lba: 32'hDEADBEEF, wdata: 8'hC3,
                wait_cycles: 8, nstrobe: 0, exp_grant: 6'b000001, exp_rd: 1'b0, exp_wr: 1'b1,
                exp_err: 6'b0};
    vecs[5] = '{idx: REQ_FLT, rd: 1'b1, wr: 1'b0, lba: 32'hFFFFFFFF, wdata: 8'hFF,
                wait_cycles: 6, nstrobe: 3, exp_grant: 6'b100000, exp_rd: 1'b1, exp_wr: 1'b0,
                exp_err: 6'b0};

    bus.req_lba           = '0;
    bus.req_rd            = '0;
    bus.req_wr            = '0;
    bus.req_wr_data       = '0;
    bus.sd_busy           = 1'b0;
    bus.sd_done           = 1'b0;
    bus.sd_rd_byte_strobe = 1'b0;

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_busy", 64'(bus.req_busy), 64'(0));
    chk("rst_cmd", 64'({bus.sd_rd, bus.sd_wr}), 64'(0));
    chk("rst_lba", 64'(bus.sd_lba), 64'(0));
    chk("rst_done_err", 64'({bus.req_done, bus.req_err}), 64'(0));

    // Contention from reset: search starts at index 0.
    step();
    set_req(REQ_C1541, 1'b1, 1'b0, 32'hA0, 8'h00);
    set_req(REQ_ROM, 1'b1, 1'b0, 32'hA3, 8'h00);
    step();
    clr_req();
    chk("cont_busy", 64'(bus.req_busy), 64'(6'b001001));
    step();
    chk("cont_first", 64'(bus.grant), 64'(6'b000001));
    chk("cont_first_lba", 64'(bus.sd_lba), 64'(32'hA0));
    serve(6'b000001, "cont0");
    step();
    chk("cont_second", 64'(bus.grant), 64'(6'b001000));
    chk("cont_second_lba", 64'(bus.sd_lba), 64'(32'hA3));
    serve(6'b001000, "cont3");

    // Rotation: 0 and 3 queue up behind owner 1, so the search from 2 finds 3 first.
    step();
    set_req(REQ_CRT, 1'b1, 1'b0, 32'hB1, 8'h00);
    step();
    clr_req();
    step();
    chk("rot_own1", 64'(bus.grant), 64'(6'b000010));
    bus.sd_busy = 1'b1;
    step();
    bus.sd_busy = 1'b0;
    set_req(REQ_C1541, 1'b1, 1'b0, 32'hB0, 8'h00);
    set_req(REQ_ROM, 1'b1, 1'b0, 32'hB3, 8'h00);
    step();
    clr_req();
    chk("rot_busy", 64'(bus.req_busy), 64'(6'b001011));
    bus.sd_done = 1'b1;
    step();
    bus.sd_done = 1'b0;
    chk("rot_done1", 64'(bus.req_done), 64'(6'b000010));
    step();
    chk("rot_first3", 64'(bus.grant), 64'(6'b001000));
    serve(6'b001000, "rot3");
    step();
    chk("rot_then0", 64'(bus.grant), 64'(6'b000001));
    chk("rot_then0_lba", 64'(bus.sd_lba), 64'(32'hB0));
    serve(6'b000001, "rot0");

    // A repeated request while pending keeps the first LBA.
    step();
    set_req(REQ_TAP, 1'b1, 1'b0, 32'hC4, 8'h00);
    step();
    clr_req();
    step();
    chk("keep_own4", 64'(bus.grant), 64'(6'b010000));
    set_req(REQ_CRT, 1'b1, 1'b0, 32'h10, 8'h00);
    step();
    set_req(REQ_CRT, 1'b1, 1'b0, 32'h20, 8'h00);
    step();
    clr_req();
    chk("keep_busy", 64'(bus.req_busy), 64'(6'b010010));
    serve(6'b010000, "keep4");
    step();
    chk("keep_own1", 64'(bus.grant), 64'(6'b000010));
    chk("keep_lba", 64'(bus.sd_lba), 64'(32'h10));
    serve(6'b000010, "keep1");

    // Issue timeout on a write from 5, with 2 queued behind it.
    step();
    set_req(REQ_FLT, 1'b0, 1'b1, 32'h55, 8'h00);
    step();
    clr_req();
    step();
    chk("tmo_grant", 64'(bus.grant), 64'(6'b100000));
    chk("tmo_sd_wr", 64'(bus.sd_wr), 64'(1));
    set_req(REQ_PRG, 1'b1, 1'b0, 32'h22, 8'h00);
    n = 0;
    while (bus.sd_wr && n < 200) begin
      n++;
      step();
      clr_req();
    end
    chk("tmo_cycles", 64'(n), 64'(Tmo));
    chk("tmo_err", 64'(bus.req_err), 64'(6'b100000));
    chk("tmo_grant_clr", 64'(bus.grant), 64'(0));
    chk("tmo_busy", 64'(bus.req_busy), 64'(6'b000100));
    step();
    chk("tmo_err_once", 64'(bus.req_err), 64'(0));
    chk("tmo_next", 64'(bus.grant), 64'(6'b000100));
    chk("tmo_next_rd", 64'(bus.sd_rd), 64'(1));
    chk("tmo_next_lba", 64'(bus.sd_lba), 64'(32'h22));
    serve(6'b000100, "tmo2");

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Async reset while the owner waits for sd_done.
    step();
    set_req(REQ_PRG, 1'b1, 1'b0, 32'h77, 8'h00);
    step();
    clr_req();
    step();
    chk("rmid_grant", 64'(bus.grant), 64'(6'b000100));
    bus.sd_busy = 1'b1;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_grant_clr", 64'(bus.grant), 64'(0));
    chk("rmid_busy_clr", 64'(bus.req_busy), 64'(0));
    chk("rmid_cmd_clr", 64'({bus.sd_rd, bus.sd_wr}), 64'(0));
    chk("rmid_lba_clr", 64'(bus.sd_lba), 64'(0));
    step();
    reset_n     = 1'b1;
    bus.sd_busy = 1'b0;
    step();
    bus.sd_done = 1'b1;
    step();
    bus.sd_done = 1'b0;
    chk("rmid_stray_done", 64'(bus.req_done), 64'(0));
    step();
    chk("rmid_stray_done2", 64'(bus.req_done), 64'(0));
    chk("rmid_idle_grant", 64'(bus.grant), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
